// File: rtl/debug_unit_pkt_if.sv
// Port bundle between debug_unit_pkt and its UART / datapath neighbours.
// master = the debug unit, slave = the surrounding UART and datapath.
interface debug_unit_pkt_if #(
    parameter int NB_WORD  = 32,
    parameter int NB_DMW   = 8,
    parameter int RB_DEPTH = 32,
    parameter int DM_DEPTH = 128,
    parameter int IM_DEPTH = 256
);
    localparam int RBW = $clog2(RB_DEPTH);
    localparam int DMW = $clog2(DM_DEPTH);
    localparam int IMW = $clog2(IM_DEPTH);

    logic               i_rx_done;
    logic [7:0]         i_rx_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic               i_hlt;
    logic [NB_WORD-1:0] i_pc_value;
    logic [NB_WORD-1:0] i_br_data;
    logic [NB_DMW-1:0]  i_dm_data;
    logic [RBW-1:0]     o_rb_addr;
    logic [DMW-1:0]     o_dm_addr;
    logic               o_rd_enable;
    logic [IMW-1:0]     o_im_addr;
    logic [7:0]         o_im_data;
    logic               o_im_we;
    logic               o_cpu_en;
    logic               o_step;
    logic [3:0]         o_state;

    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_hlt, i_pc_value, i_br_data, i_dm_data,
        output o_tx_start, o_tx_data, o_rb_addr, o_dm_addr, o_rd_enable,
               o_im_addr, o_im_data, o_im_we, o_cpu_en, o_step, o_state
    );

    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_hlt, i_pc_value, i_br_data, i_dm_data,
        input  o_tx_start, o_tx_data, o_rb_addr, o_dm_addr, o_rd_enable,
               o_im_addr, o_im_data, o_im_we, o_cpu_en, o_step, o_state
    );
endinterface

// File: rtl/debug_unit_pkt.sv
// UART debug controller: length-prefixed IM load, run/step control, PC/RB/DM dumps with XOR checksum.
// Breakpoint support is compiled in when DEBUG_UNIT_BREAKPOINT_EN is defined.
module debug_unit_pkt #(
    parameter int NB_DATA  = 8,
    parameter int NB_WORD  = 32,
    parameter int NB_DMW   = 8,
    parameter int RB_DEPTH = 32,
    parameter int DM_DEPTH = 128,
    parameter int IM_DEPTH = 256
) (
    input  logic             i_clock,
    input  logic             i_reset,
    debug_unit_pkt_if.master bus
);
    localparam int BPW = NB_WORD / NB_DATA;
    localparam int BPD = NB_DMW / NB_DATA;
    localparam int RBW = $clog2(RB_DEPTH);
    localparam int DMW = $clog2(DM_DEPTH);
    localparam int IMW = $clog2(IM_DEPTH);
    localparam int CW  = (RBW > DMW) ? RBW : DMW;
    localparam int BCW = $clog2(BPW + 1);
    localparam int LW  = IMW + 1;

    localparam logic [7:0] CMD_LOAD     = 8'h01;
    localparam logic [7:0] CMD_RUN      = 8'h02;
    localparam logic [7:0] CMD_STEPMODE = 8'h03;
    localparam logic [7:0] CMD_DUMP_RB  = 8'h04;
    localparam logic [7:0] CMD_DUMP_DM  = 8'h05;
    localparam logic [7:0] CMD_DUMP_PC  = 8'h06;
    localparam logic [7:0] CMD_STEP     = 8'h07;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
    localparam logic [7:0] CMD_SET_BP   = 8'h09;
    localparam logic [7:0] CMD_CLR_BP   = 8'h0A;
`endif

    typedef enum logic [3:0] {
        IDLE = 4'd1, LOAD_LEN = 4'd2, LOAD_IM = 4'd3, READY = 4'd4, RUN = 4'd5,
        STEP = 4'd6, DUMP_PC = 4'd7, DUMP_RB = 4'd8, DUMP_DM = 4'd9, SET_BP = 4'd10
    } state_t;

    typedef enum logic [1:0] {P_ADDR, P_LATCH, P_SEND, P_WAIT} phase_t;

    state_t               state, state_nxt;
    phase_t               phase;
    logic                 sending_csum, chain, len_idx;
    logic [7:0]           len_hi, csum, tx_data, im_data;
    logic                 tx_start, im_we, step;
    logic [LW-1:0]        load_n, wr_cnt;
    logic [IMW-1:0]       im_addr;
    logic [CW-1:0]        word_cnt;
    logic [BCW-1:0]       byte_cnt, cur_bytes;
    logic [NB_WORD-1:0]   word_sr;
    logic                 rx_done, in_dump, last_word, dump_done, bp_hit, cpu_en;
    logic [7:0]           rx;
    logic [15:0]          len_full;

    assign rx        = bus.i_rx_data;
    assign rx_done   = bus.i_rx_done;
    assign len_full  = {len_hi, rx};
    assign in_dump   = state inside {DUMP_PC, DUMP_RB, DUMP_DM};
    assign cur_bytes = (state == DUMP_DM) ? BCW'(BPD) : BCW'(BPW);
    assign dump_done = in_dump && phase == P_WAIT && bus.i_tx_done && sending_csum;

    always_comb begin
        case (state)
            DUMP_RB: last_word = (word_cnt == CW'(RB_DEPTH - 1));
            DUMP_DM: last_word = (word_cnt == CW'(DM_DEPTH - 1));
            default: last_word = 1'b1;
        endcase
    end

`ifdef DEBUG_UNIT_BREAKPOINT_EN
    state_t             ret_state;
    logic [NB_WORD-1:0] bp_addr;
    logic               bp_valid, bp_hold;
    logic [BCW-1:0]     bp_cnt;

    assign bp_hit = bp_valid && (bus.i_pc_value == bp_addr);
    // A breakpoint parks the core in STEP with the clock gated until the next command.
    assign cpu_en = (state == RUN) || (state == STEP && !bp_hold);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ret_state <= IDLE;
            bp_addr   <= '0;
            bp_valid  <= 1'b0;
            bp_hold   <= 1'b0;
            bp_cnt    <= '0;
        end else begin
            if ((state == IDLE || state == READY) && rx_done && rx == CMD_SET_BP) begin
                ret_state <= state;
                bp_cnt    <= '0;
            end
            if ((state inside {IDLE, READY, STEP}) && rx_done && rx == CMD_CLR_BP)
                bp_valid <= 1'b0;
            if (state == SET_BP && rx_done) begin
                bp_addr <= {bp_addr[NB_WORD-NB_DATA-1:0], rx};
                bp_cnt  <= bp_cnt + BCW'(1);
                bp_valid <= (bp_cnt == BCW'(BPW - 1));
            end
            if (state == RUN && state_nxt == STEP)
                bp_hold <= 1'b1;
            else if (state_nxt != STEP || (rx_done && (rx == CMD_STEP || rx == CMD_RUN)))
                bp_hold <= 1'b0;
        end
    end
`else
    assign bp_hit = 1'b0;
    assign cpu_en = (state == RUN) || (state == STEP);
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rx_done) begin
                case (rx)
                    CMD_LOAD:    state_nxt = LOAD_LEN;
                    CMD_DUMP_RB: state_nxt = DUMP_RB;
                    CMD_DUMP_DM: state_nxt = DUMP_DM;
                    CMD_DUMP_PC: state_nxt = DUMP_PC;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
                    CMD_SET_BP:  state_nxt = SET_BP;
`endif
                    default: ;
                endcase
            end
            LOAD_LEN: if (rx_done && len_idx) state_nxt = (len_full == 16'd0) ? READY : LOAD_IM;
            LOAD_IM:  if (rx_done && (wr_cnt + LW'(1) == load_n)) state_nxt = READY;
            READY: if (rx_done) begin
                case (rx)
                    CMD_RUN:      state_nxt = RUN;
                    CMD_STEPMODE: state_nxt = STEP;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
                    CMD_SET_BP:   state_nxt = SET_BP;
`endif
                    default: ;
                endcase
            end
            RUN: begin
                if (bus.i_hlt)   state_nxt = IDLE;
                else if (bp_hit) state_nxt = STEP;
            end
            STEP: begin
                if (bus.i_hlt)                       state_nxt = IDLE;
                else if (rx_done && rx == CMD_STEP) state_nxt = DUMP_PC;
                else if (rx_done && rx == CMD_RUN)  state_nxt = RUN;
            end
            DUMP_PC: if (dump_done) state_nxt = chain ? DUMP_RB : IDLE;
            DUMP_RB: if (dump_done) state_nxt = chain ? DUMP_DM : IDLE;
            DUMP_DM: if (dump_done) state_nxt = chain ? STEP : IDLE;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
            SET_BP:  if (rx_done && bp_cnt == BCW'(BPW - 1)) state_nxt = ret_state;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            phase        <= P_ADDR;
            sending_csum <= 1'b0;
            chain        <= 1'b0;
            len_idx      <= 1'b0;
            len_hi       <= '0;
            csum         <= '0;
            tx_data      <= '0;
            im_data      <= '0;
            tx_start     <= 1'b0;
            im_we        <= 1'b0;
            step         <= 1'b0;
            load_n       <= '0;
            wr_cnt       <= '0;
            im_addr      <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            word_sr      <= '0;
        end else begin
            tx_start <= 1'b0;
            im_we    <= 1'b0;
            step     <= (state == STEP && state_nxt == DUMP_PC);

            if (state == STEP && state_nxt == DUMP_PC)       chain <= 1'b1;
            else if (state_nxt == IDLE || state_nxt == STEP) chain <= 1'b0;

            if (state == LOAD_LEN && rx_done) begin
                if (!len_idx) begin
                    len_hi  <= rx;
                    len_idx <= 1'b1;
                end else begin
                    len_idx <= 1'b0;
                    wr_cnt  <= '0;
                    load_n  <= (len_full > 16'(IM_DEPTH)) ? LW'(IM_DEPTH) : len_full[LW-1:0];
                end
            end

            if (state == LOAD_IM && rx_done) begin
                im_we   <= 1'b1;
                im_data <= rx;
                im_addr <= wr_cnt[IMW-1:0];
                wr_cnt  <= wr_cnt + LW'(1);
            end

            // Dump engine: address -> latch word -> per byte (send, wait tx_done) -> checksum.
            if (in_dump) begin
                case (phase)
                    P_ADDR: phase <= P_LATCH;
                    P_LATCH: begin
                        case (state)
                            DUMP_PC: word_sr <= bus.i_pc_value;
                            DUMP_RB: word_sr <= bus.i_br_data;
                            default: word_sr <= NB_WORD'(bus.i_dm_data) << (NB_WORD - NB_DMW);
                        endcase
                        phase <= P_SEND;
                    end
                    P_SEND: begin
                        tx_start <= 1'b1;
                        if (sending_csum) begin
                            tx_data <= csum;
                            csum    <= '0;
                        end else begin
                            tx_data  <= word_sr[NB_WORD-1 -: NB_DATA];
                            csum     <= csum ^ word_sr[NB_WORD-1 -: NB_DATA];
                            word_sr  <= word_sr << NB_DATA;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                        phase <= P_WAIT;
                    end
                    P_WAIT: if (bus.i_tx_done) begin
                        if (sending_csum) begin
                            sending_csum <= 1'b0;
                            word_cnt     <= '0;
                            phase        <= P_ADDR;
                        end else if (byte_cnt == cur_bytes) begin
                            byte_cnt <= '0;
                            if (last_word) begin
                                sending_csum <= 1'b1;
                                phase        <= P_SEND;
                            end else begin
                                word_cnt <= word_cnt + CW'(1);
                                phase    <= P_ADDR;
                            end
                        end else begin
                            phase <= P_SEND;
                        end
                    end
                    default: phase <= P_ADDR;
                endcase
            end
        end
    end

    assign bus.o_tx_start  = tx_start;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_rb_addr   = word_cnt[RBW-1:0];
    assign bus.o_dm_addr   = word_cnt[DMW-1:0];
    assign bus.o_rd_enable = (state == DUMP_RB) || (state == DUMP_DM);
    assign bus.o_im_addr   = im_addr;
    assign bus.o_im_data   = im_data;
    assign bus.o_im_we     = im_we;
    assign bus.o_cpu_en    = cpu_en;
    assign bus.o_step      = step;
    assign bus.o_state     = state;
endmodule

// File: tb/tb_debug_unit_pkt.sv
// Directed bench for debug_unit_pkt: expected TX bytes queued at stimulus time, popped as the DUT sends.
module tb_debug_unit_pkt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int starts = 0;
    logic [7:0] exp_q[$];
    logic [7:0] xs = 8'h00;

    debug_unit_pkt_if bus ();
    debug_unit_pkt dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] rb_val(input int i);
        return 32'hA500_3C00 ^ (32'(i) * 32'h0103_0507);
    endfunction

    function automatic logic [7:0] dm_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous-read memory models: data valid one cycle after the address.
    always @(posedge clk) begin
        bus.i_br_data <= rb_val(int'(bus.o_rb_addr));
        bus.i_dm_data <= dm_val(int'(bus.o_dm_addr));
    end

    always @(posedge clk) if (bus.o_tx_start === 1'b1) starts <= starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] b);
        exp_q.push_back(b);
        xs = xs ^ b;
    endtask

    task automatic push_sum();
        exp_q.push_back(xs);
        xs = 8'h00;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) push_b(w[8*k +: 8]);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        bit seen;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            seen = 1'b0;
            for (int n = 0; n < 200 && !seen; n++) begin
                if (bus.o_tx_start === 1'b1) seen = 1'b1;
                else tick();
            end
            chk({tag, "_start"}, 32'(seen), 32'd1);
            if (!seen) begin
                exp_q.delete();
                return;
            end
            chk(tag, 32'(bus.o_tx_data), 32'(e));
            tick();
            tick();
            bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
        end
    endtask

    initial begin
        int s0;
        bus.i_rx_done  = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_done  = 1'b0;
        bus.i_hlt      = 1'b0;
        bus.i_pc_value = 32'h0;

        tick();
        tick();
        chk("reset_state", 32'(bus.o_state), 32'd1);
        chk("reset_outs", 32'({bus.o_tx_start, bus.o_tx_data, bus.o_rb_addr, bus.o_dm_addr,
            bus.o_rd_enable, bus.o_im_addr, bus.o_im_data, bus.o_im_we, bus.o_cpu_en, bus.o_step}), 32'd0);
        rst = 1'b0;
        tick();

        // Async reset in the middle of an IM load
        send(8'h01); send(8'h00); send(8'h02); send(8'h11);
        chk("midload_we", 32'(bus.o_im_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_state", 32'(bus.o_state), 32'd1);
        chk("async_outs", 32'({bus.o_tx_start, bus.o_im_we, bus.o_im_addr, bus.o_im_data, bus.o_cpu_en, bus.o_step}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(8'h22);
        chk("post_rst_we", 32'(bus.o_im_we), 32'd0);
        chk("post_rst_state", 32'(bus.o_state), 32'd1);

        // Zero-length load, then RUN and halt
        send(8'h01); send(8'h00); send(8'h00);
        chk("len0_ready", 32'(bus.o_state), 32'd4);
        send(8'h02);
        chk("run_state", 32'(bus.o_state), 32'd5);
        chk("run_cpu_en", 32'(bus.o_cpu_en), 32'd1);
        bus.i_hlt = 1'b1; tick(); bus.i_hlt = 1'b0;
        chk("hlt_idle", 32'(bus.o_state), 32'd1);

        send(8'h55);
        chk("unknown_ignored", 32'(bus.o_state), 32'd1);
        send(8'h07);
        chk("step_in_idle", 32'(bus.o_state), 32'd1);

        // PC dump
        bus.i_pc_value = 32'h0000_0040;
        s0 = starts;
        push_word(32'h0000_0040); push_sum();
        send(8'h06);
        drain("pc_dump");
        tick();
        chk("pc_dump_starts", 32'(starts - s0), 32'd5);
        chk("pc_dump_idle", 32'(bus.o_state), 32'd1);

`ifdef DEBUG_UNIT_BREAKPOINT_EN
        send(8'h09);
        chk("setbp_state", 32'(bus.o_state), 32'd10);
        send(8'h00); send(8'h00); send(8'h00);
        chk("setbp_hold", 32'(bus.o_state), 32'd10);
        send(8'h10);
        chk("setbp_ret", 32'(bus.o_state), 32'd1);
`else
        send(8'h09);
        chk("bp_cmd_ignored", 32'(bus.o_state), 32'd1);
        send(8'h00); send(8'h00); send(8'h00); send(8'h10);
        chk("bp_bytes_ignored", 32'(bus.o_state), 32'd1);
`endif

        // IM load of four bytes
        send(8'h01); send(8'h00); send(8'h04);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'hAA + 8'(i * 8'h11);
            send(b);
            chk("im_we", 32'(bus.o_im_we), 32'd1);
            chk("im_addr", 32'(bus.o_im_addr), 32'(i));
            chk("im_data", 32'(bus.o_im_data), 32'(b));
        end
        tick();
        chk("im_we_low", 32'(bus.o_im_we), 32'd0);
        chk("load_ready", 32'(bus.o_state), 32'd4);

        // Step mode: one step then chained PC/RB/DM dump
        bus.i_pc_value = 32'h0000_0124;
        send(8'h03);
        chk("stepmode", 32'(bus.o_state), 32'd6);
        chk("step_cpu_en", 32'(bus.o_cpu_en), 32'd1);
        push_word(32'h0000_0124); push_sum();
        for (int i = 0; i < 32; i++) push_word(rb_val(i));
        push_sum();
        for (int i = 0; i < 128; i++) push_b(dm_val(i));
        push_sum();
        s0 = starts;
        send(8'h07);
        chk("step_pulse", 32'(bus.o_step), 32'd1);
        chk("step_dump_pc", 32'(bus.o_state), 32'd7);
        tick();
        chk("step_pulse_end", 32'(bus.o_step), 32'd0);
        drain("step_dump");
        tick();
        chk("step_dump_starts", 32'(starts - s0), 32'd263);
        chk("step_return", 32'(bus.o_state), 32'd6);

        // RUN from STEP, rx ignored, halt
        send(8'h02);
        chk("run2_state", 32'(bus.o_state), 32'd5);
        s0 = starts;
        send(8'h07);
        chk("run_rx_ignored", 32'(bus.o_state), 32'd5);
        bus.i_hlt = 1'b1; tick(); bus.i_hlt = 1'b0;
        chk("hlt_cpu_en", 32'(bus.o_cpu_en), 32'd0);
        chk("hlt_state", 32'(bus.o_state), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("run_no_tx", 32'(starts - s0), 32'd0);

        // Length saturates at IM_DEPTH
        send(8'h01); send(8'h01); send(8'h05);
        chk("sat_load_im", 32'(bus.o_state), 32'd3);
        for (int i = 0; i < 256; i++) begin
            send(8'(i) ^ 8'h5A);
            chk("sat_addr", 32'(bus.o_im_addr), 32'(i));
            if (i == 254) chk("sat_not_done", 32'(bus.o_state), 32'd3);
        end
        chk("sat_ready", 32'(bus.o_state), 32'd4);

`ifdef DEBUG_UNIT_BREAKPOINT_EN
        bus.i_pc_value = 32'h0000_000C;
        send(8'h02);
        chk("bp_run", 32'(bus.o_state), 32'd5);
        tick();
        chk("bp_no_hit", 32'(bus.o_state), 32'd5);
        bus.i_pc_value = 32'h0000_0010;
        tick();
        chk("bp_hit_state", 32'(bus.o_state), 32'd6);
        chk("bp_hit_cpu_en", 32'(bus.o_cpu_en), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
